// File: rtl/falling_detector_pkg.sv
// Shared constants and helpers for the fall detector.
package falling_detector_pkg;

    localparam int unsigned FD_WIDTH_DEFAULT = 8;

    // Persistence counter width: ceil(log2(persist+1)), never below 1 bit.
    function automatic int unsigned fd_cnt_width(input int unsigned persist);
        int unsigned w;
        w = $clog2(persist + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/falling_detector_compare.sv
// Unsigned strict less-than: below_o is high when a_i < b_i.
module fd_compare
    import falling_detector_pkg::*;
#(
    parameter int unsigned WIDTH = FD_WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             below_o
);

    // Equal and greater both count as not below.
    assign below_o = (a_i < b_i);

endmodule

// File: rtl/falling_detector.sv
// Fall detector: qualifies a below-threshold sensor reading over PERSIST
// consecutive cycles and keeps a sticky record of any detection.
module falling_detector
    import falling_detector_pkg::*;
#(
    parameter int unsigned WIDTH   = FD_WIDTH_DEFAULT,
    parameter int unsigned PERSIST = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] fdSensorValue,
    input  logic [WIDTH-1:0] fdFactoryValue,
    input  logic             fdClear,
    output logic             fallDetected,
    output logic             fallLatched
);

    localparam int unsigned CW = fd_cnt_width(PERSIST);
    localparam logic [CW-1:0] PERSIST_C  = CW'(PERSIST);
    localparam logic [CW:0]   PERSIST_W  = (CW + 1)'(PERSIST);

    logic          below;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          det_q, det_d;
    logic          latch_q, latch_d;

    fd_compare #(
        .WIDTH (WIDTH)
    ) u_compare (
        .a_i     (fdSensorValue),
        .b_i     (fdFactoryValue),
        .below_o (below)
    );

    // Next-state: saturating persistence count, qualification, sticky latch.
    always_comb begin
        cnt_d   = '0;
        det_d   = 1'b0;
        latch_d = latch_q;
        if (below) begin
            cnt_d = (cnt_q == PERSIST_C) ? cnt_q : cnt_q + CW'(1);
            // One bit wider so cnt_q+1 cannot wrap.
            det_d = (({1'b0, cnt_q} + (CW + 1)'(1)) >= PERSIST_W);
        end
        // A new detection overrides a simultaneous clear.
        if (det_d) begin
            latch_d = 1'b1;
        end else if (fdClear) begin
            latch_d = 1'b0;
        end
    end

    // State registers with synchronous reset having top priority.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            det_q   <= 1'b0;
            latch_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            det_q   <= det_d;
            latch_q <= latch_d;
        end
    end

    assign fallDetected = det_q;
    assign fallLatched  = latch_q;

endmodule

// File: tb/tb_falling_detector.sv
// Directed bench for falling_detector with PERSIST=1 and PERSIST=3 instances.
module tb_falling_detector;

    logic       clk;
    logic       r1, c1, d1, l1;
    logic [7:0] s1, f1;
    logic       r3, c3, d3, l3;
    logic [7:0] s3, f3;

    int vectors;
    int errs;

    falling_detector #(.WIDTH(8), .PERSIST(1)) dut1 (
        .clk            (clk),
        .reset          (r1),
        .fdSensorValue  (s1),
        .fdFactoryValue (f1),
        .fdClear        (c1),
        .fallDetected   (d1),
        .fallLatched    (l1)
    );

    falling_detector #(.WIDTH(8), .PERSIST(3)) dut3 (
        .clk            (clk),
        .reset          (r3),
        .fdSensorValue  (s3),
        .fdFactoryValue (f3),
        .fdClear        (c3),
        .fallDetected   (d3),
        .fallLatched    (l3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    initial begin
        vectors = 0;
        errs    = 0;
        r1 = 1'b1; c1 = 1'b0; s1 = 8'd0; f1 = 8'd0;
        r3 = 1'b1; c3 = 1'b0; s3 = 8'd0; f3 = 8'd0;

        // ---------------- PERSIST=1 ----------------
        tick();
        check("p1_reset_det", d1, 1'b0);
        check("p1_reset_lat", l1, 1'b0);
        r1 = 1'b0;

        // Idle zero inputs
        for (int i = 0; i < 3; i++) begin
            tick();
            check("p1_idle_det", d1, 1'b0);
            check("p1_idle_lat", l1, 1'b0);
        end
        s1 = 8'd255; f1 = 8'd255;
        tick();
        check("p1_eq255_det", d1, 1'b0);
        check("p1_eq255_lat", l1, 1'b0);

        // Threshold sweep, factory=7
        f1 = 8'd7;
        for (int v = 1; v <= 9; v++) begin
            s1 = 8'(v);
            tick();
            check("p1_sweep_det", d1, (v < 7) ? 1'b1 : 1'b0);
            check("p1_sweep_lat", l1, 1'b1);
        end

        // Sticky clear with no fall
        s1 = 8'd200; c1 = 1'b1;
        tick();
        check("p1_clr_det", d1, 1'b0);
        check("p1_clr_lat", l1, 1'b0);
        c1 = 1'b0;
        tick();
        check("p1_clr_hold", l1, 1'b0);

        // Set wins over held clear
        s1 = 8'd10; f1 = 8'd20; c1 = 1'b1;
        tick();
        check("p1_setwin_det", d1, 1'b1);
        check("p1_setwin_lat", l1, 1'b1);
        tick();
        check("p1_setwin_lat2", l1, 1'b1);
        c1 = 1'b0;

        // Width extremes
        s1 = 8'd0; f1 = 8'd255;
        tick();
        check("p1_0v255", d1, 1'b1);
        s1 = 8'd254;
        tick();
        check("p1_254v255", d1, 1'b1);
        s1 = 8'd255; f1 = 8'd0;
        tick();
        check("p1_255v0", d1, 1'b0);
        check("p1_255v0_lat", l1, 1'b1);
        s1 = 8'd0; f1 = 8'd0;
        tick();
        check("p1_f0_det", d1, 1'b0);

        // Long below run
        s1 = 8'd0; f1 = 8'd255;
        for (int i = 0; i < 300; i++) begin
            tick();
            check("p1_sat_det", d1, 1'b1);
        end
        s1 = 8'd255;
        tick();
        check("p1_sat_drop", d1, 1'b0);

        // ---------------- PERSIST=3 ----------------
        tick();
        check("p3_reset_det", d3, 1'b0);
        check("p3_reset_lat", l3, 1'b0);
        r3 = 1'b0;

        // Two below then a break: no detection
        f3 = 8'd100; s3 = 8'd50;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("p3_short_det", d3, 1'b0);
        end
        s3 = 8'd150;
        tick();
        check("p3_break_det", d3, 1'b0);
        check("p3_break_lat", l3, 1'b0);

        // Three below: detect on the third, hold, then drop on equality
        s3 = 8'd50;
        tick(); check("p3_run1", d3, 1'b0);
        tick(); check("p3_run2", d3, 1'b0);
        tick(); check("p3_run3", d3, 1'b1);
        check("p3_run3_lat", l3, 1'b1);
        tick(); check("p3_run4", d3, 1'b1);
        tick(); check("p3_run5", d3, 1'b1);
        s3 = 8'd100;
        tick();
        check("p3_eq_drop", d3, 1'b0);
        check("p3_eq_lat", l3, 1'b1);

        // Reset mid-count
        s3 = 8'd50;
        tick(); check("p3_pre_rst1", d3, 1'b0);
        tick(); check("p3_pre_rst2", d3, 1'b0);
        r3 = 1'b1;
        tick();
        check("p3_rst_det", d3, 1'b0);
        check("p3_rst_lat", l3, 1'b0);
        r3 = 1'b0;
        tick(); check("p3_post1", d3, 1'b0);
        tick(); check("p3_post2", d3, 1'b0);
        tick(); check("p3_post3", d3, 1'b1);

        // Threshold moves below the sensor mid-run
        f3 = 8'd40;
        tick();
        check("p3_thr_drop", d3, 1'b0);
        f3 = 8'd100;
        tick(); check("p3_thr_re1", d3, 1'b0);

        // Saturation over a long run
        s3 = 8'd100;
        tick();
        check("p3_sat_pre", d3, 1'b0);
        s3 = 8'd50;
        for (int i = 0; i < 300; i++) begin
            tick();
            check("p3_sat_det", d3, (i >= 2) ? 1'b1 : 1'b0);
        end
        s3 = 8'd200; c3 = 1'b1;
        tick();
        check("p3_sat_drop", d3, 1'b0);
        check("p3_clr_lat", l3, 1'b0);
        c3 = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule

// File: doc/falling_detector.md
Name: falling_detector

Overview:
- Fall detector for the sensor-monitoring datapath.
- Each clock it compares a live sensor reading (fdSensorValue) against a factory-calibrated threshold (fdFactoryValue).
- It raises fallDetected when the reading stays strictly below the threshold for a configurable number of consecutive cycles.
- A sticky flag (fallLatched) records that a fall occurred until it is cleared; downstream alarm/control logic consumes both outputs.

Parameters:
- WIDTH, 8, bit width of sensor and factory values (unsigned).
- PERSIST, 1, consecutive below-threshold samples required before fallDetected asserts (legal range 1..255).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- fdSensorValue  input  WIDTH  current sensor reading, unsigned, sampled every cycle.
- fdFactoryValue  input  WIDTH  factory threshold, unsigned, sampled every cycle (may change at any time).
- fdClear  input  1  synchronous clear of fallLatched; active-high, one-cycle pulse sufficient.
- fallDetected  output  1  registered; high while the fall condition is qualified.
- fallLatched  output  1  registered sticky flag; set when fallDetected sets, held until fdClear or reset.

Behaviour:
- One clock domain, clk. Reset is synchronous and active-high.
- Reset (sampled high at a clk edge): persistence counter = 0, fallDetected = 0, fallLatched = 0. Reset has priority over all other inputs.
- below = (fdSensorValue < fdFactoryValue), unsigned comparison, full WIDTH. Equal is NOT below. Greater is NOT below.
- Persistence counter cnt, width ceil(log2(PERSIST+1)), minimum 1 bit:
  - below=1: cnt <= min(cnt+1, PERSIST), saturating with no wrap-around.
  - below=0: cnt <= 0 in the same edge.
- fallDetected <= below && (cnt+1 >= PERSIST). The addition is computed one bit wider so it cannot overflow.
- Latency with PERSIST=1: fallDetected reflects the inputs present at the previous rising edge (1-cycle latency).
- Latency with PERSIST=N: asserts at the Nth consecutive below edge.
- Deassertion: the first edge that samples below=0 drops fallDetected and zeroes cnt. No hysteresis.
- fallLatched:
  - Next value is 1 if the new fallDetected is 1.
  - Otherwise 0 if fdClear=1.
  - Otherwise it holds.
  - Set wins over a simultaneous fdClear.
- A threshold change mid-run is treated like a sensor change: below is re-evaluated each edge.
- fdFactoryValue=0 means below is never true, so no fall can ever be detected.
- Reset asserted mid-run (including mid-persistence count) discards all progress. Counting restarts from 0 on the first edge after reset deasserts.
- No combinational path from inputs to outputs. Outputs are stable between edges.
- No X propagation from counter: all state is reset.

Decomposition:
- Shared package falling_detector_pkg holds:
  - the default WIDTH constant;
  - a function computing counter width from PERSIST.
- One natural sub-module: fd_compare, a pure combinational unsigned less-than of WIDTH bits producing below.
- Counter, qualification and latch logic live in the top module.

Test Plan:
- Threshold sweep, PERSIST=1: reset, then fdFactoryValue=7 and fdSensorValue stepped 1,2,3,4,5,6,7,8,9, one value per edge.
  - Sensors 1..6: fallDetected=1 one cycle after each is applied.
  - Sensors 7, 8, 9: fallDetected=0.
  - fallLatched=1 from the first detection and remaining 1 through 7..9.
- Idle/equality: both inputs 0 after reset -> fallDetected=0, fallLatched=0 indefinitely. Sensor=255, factory=255 -> 0.
- Persistence, PERSIST=3, factory=100:
  - sensor=50 for 2 edges, then 150 for 1 edge -> fallDetected stays 0.
  - sensor=50 for 3 consecutive edges -> fallDetected=1 at the 3rd edge, held while 50 persists, cleared on the first edge with sensor=100.
- Sticky clear:
  - After a detection, sensor=200 and pulse fdClear -> fallLatched=0 the next cycle.
  - With fdClear held high while sensor=10, factory=20 -> fallLatched=1 (set wins).
- Reset mid-operation:
  - With PERSIST=3, factory=100, sensor=50 for 2 edges, assert reset 1 cycle -> outputs 0.
  - After release with sensor=50, detection takes 3 further edges.
- Width extremes, PERSIST=1:
  - sensor=0, factory=255 -> fallDetected=1.
  - sensor=254, factory=255 -> 1.
  - sensor=255, factory=0 -> 0.
  - Counter saturates, with no spurious drop, after 300 consecutive below cycles.
